// File: rtl/exu_cal_arb_pkg.sv
// rtl/exu_cal_arb_pkg.sv - shared encodings for the cal arbiter (requester ids, states, watchdog default)
`ifndef CIRNO_CAL_OPB_SIZE
`define CIRNO_CAL_OPB_SIZE 32
`endif

package exu_cal_arb_pkg;

  localparam logic [1:0] REQ_AL = 2'd0;
  localparam logic [1:0] REQ_BJ = 2'd1;
  localparam logic [1:0] REQ_AG = 2'd2;

  localparam int CIRNO_WDT_MAX = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  // Next requester index, wrapping AG back to AL.
  function automatic logic [1:0] idx_inc(input logic [1:0] idx);
    return (idx >= REQ_AG) ? REQ_AL : idx + 2'd1;
  endfunction

endpackage

// File: rtl/exu_cal_arb_rr_pick.sv
// rtl/exu_cal_arb_rr_pick.sv - 3-way round-robin picker: search upward from ptr with wrap
module cal_rr_pick
  import exu_cal_arb_pkg::*;
(
  input  logic [1:0] ptr_i,
  input  logic [2:0] vld_i,
  output logic [2:0] gnt_o,
  output logic [1:0] idx_o,
  output logic       any_o
);

  logic [3:0] vld4;
  logic [1:0] cand;

  assign vld4 = {1'b0, vld_i};

  always_comb begin
    gnt_o = 3'b000;
    idx_o = REQ_AL;
    any_o = 1'b0;
    cand  = ptr_i;
    for (int k = 0; k < 3; k++) begin
      if (!any_o && vld4[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
      cand = idx_inc(cand);
    end
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/exu_cal_arb.sv
// rtl/exu_cal_arb.sv - arbitrates ALU/branch/AGU requests onto one cal unit, with result routing and watchdog
`ifndef CIRNO_CAL_OPB_SIZE
`define CIRNO_CAL_OPB_SIZE 32
`endif

module exu_cal_arb
  import exu_cal_arb_pkg::*;
#(
  parameter int WDT_MAX = CIRNO_WDT_MAX,
  parameter int OPB_W   = `CIRNO_CAL_OPB_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hs_al4arb_val,
  input  logic             hs_bj4arb_val,
  input  logic             hs_ag4arb_val,
  output logic             hs_arb4al_rdy,
  output logic             hs_arb4bj_rdy,
  output logic             hs_arb4ag_rdy,
  input  logic [OPB_W-1:0] i_al_opb,
  input  logic [OPB_W-1:0] i_bj_opb,
  input  logic [OPB_W-1:0] i_ag_opb,
  output logic [31:0]      o_al_res,
  output logic [31:0]      o_bj_res,
  output logic [31:0]      o_ag_res,
  output logic             o_al_res_val,
  output logic             o_bj_res_val,
  output logic             o_ag_res_val,
  output logic             hs_arb4cal_val,
  input  logic             hs_cal4arb_rdy,
  output logic [OPB_W-1:0] o_cal_opb,
  input  logic [31:0]      i_cal_res,
  input  logic             i_cal_res_val,
  output logic             o_wdt_err
);

  localparam int WDT_W = $clog2(WDT_MAX + 1);

  arb_state_e       state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       owner_q;
  logic [WDT_W-1:0] wdt_q;

  logic [2:0] pick_gnt;
  logic [1:0] pick_idx;
  logic       pick_any;
  logic       wait_done;
  logic       arb_free;
  logic       gnt_val;
  logic [1:0] gnt_idx;
  logic       accept;
  logic       wdt_hit;

  cal_rr_pick u_pick (
    .ptr_i (ptr_q),
    .vld_i ({hs_ag4arb_val, hs_bj4arb_val, hs_al4arb_val}),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // A returning result frees the cal unit in the same cycle, so a new grant can issue back-to-back.
  assign wait_done = (state_q == ST_WAIT) && i_cal_res_val;
  assign arb_free  = (state_q == ST_IDLE) || wait_done;
  assign wdt_hit   = (state_q == ST_WAIT) && !i_cal_res_val && (wdt_q == WDT_W'(WDT_MAX - 1));

  always_comb begin
    gnt_val = 1'b0;
    gnt_idx = owner_q;
    if (state_q == ST_REQ) begin
      gnt_val = 1'b1;
    end else if (arb_free && pick_any) begin
      gnt_val = 1'b1;
      gnt_idx = pick_idx;
    end
  end

  assign accept = gnt_val && hs_cal4arb_rdy;

  always_comb begin
    o_cal_opb = '0;
    if (gnt_val) begin
      case (gnt_idx)
        REQ_AL:  o_cal_opb = i_al_opb;
        REQ_BJ:  o_cal_opb = i_bj_opb;
        REQ_AG:  o_cal_opb = i_ag_opb;
        default: o_cal_opb = '0;
      endcase
    end
  end

  assign hs_arb4cal_val = gnt_val;
  assign hs_arb4al_rdy  = accept && (gnt_idx == REQ_AL);
  assign hs_arb4bj_rdy  = accept && (gnt_idx == REQ_BJ);
  assign hs_arb4ag_rdy  = accept && (gnt_idx == REQ_AG);

  assign o_al_res_val = wait_done && (owner_q == REQ_AL);
  assign o_bj_res_val = wait_done && (owner_q == REQ_BJ);
  assign o_ag_res_val = wait_done && (owner_q == REQ_AG);
  assign o_al_res     = o_al_res_val ? i_cal_res : 32'd0;
  assign o_bj_res     = o_bj_res_val ? i_cal_res : 32'd0;
  assign o_ag_res     = o_ag_res_val ? i_cal_res : 32'd0;
  assign o_wdt_err    = wdt_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= REQ_AL;
      owner_q <= REQ_AL;
      wdt_q   <= '0;
    end else if (accept) begin
      state_q <= ST_WAIT;
      owner_q <= gnt_idx;
      ptr_q   <= idx_inc(gnt_idx);
      wdt_q   <= '0;
    end else if (gnt_val) begin
      state_q <= ST_REQ;
      owner_q <= gnt_idx;
    end else if ((state_q == ST_WAIT) && !i_cal_res_val) begin
      // Watchdog abort drops the owner's request; the requester already saw its rdy.
      if (wdt_hit) begin
        state_q <= ST_IDLE;
        wdt_q   <= '0;
      end else begin
        wdt_q <= wdt_q + 1'b1;
      end
    end else begin
      state_q <= ST_IDLE;
    end
  end

endmodule

// File: doc/exu_cal_arb.md
EXU_CAL_ARB -- requirements
Module: exu_cal_arb

Interface
REQ-001 SHALL have one clock and one reset: the clock port is clk, and the reset is rst, synchronous and active-high.
REQ-002 SHALL have parameters: WDT_MAX, default 255, meaning the number of WAIT cycles before watchdog abort; OPB_W, default `CIRNO_CAL_OPB_SIZE, meaning the cal opcode-bundle width.
REQ-003 clk  in  1  clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 hs_al4arb_val / hs_bj4arb_val / hs_ag4arb_val  in  1 each  request valid from ALU, branch unit, address generator.
REQ-006 hs_arb4al_rdy / hs_arb4bj_rdy / hs_arb4ag_rdy  out  1 each  request accepted this cycle.
REQ-007 i_al_opb / i_bj_opb / i_ag_opb  in  OPB_W each  cal opcode bundle per requester.
REQ-008 o_al_res / o_bj_res / o_ag_res  out  32 each  cal result; valid only with the matching res_val.
REQ-009 o_al_res_val / o_bj_res_val / o_ag_res_val  out  1 each  one-cycle result strobe.
REQ-010 hs_arb4cal_val  out  1  request to cal; hs_cal4arb_rdy  in  1  cal accepts.
REQ-011 o_cal_opb  out  OPB_W  muxed opcode bundle; i_cal_res  in  32  cal result; i_cal_res_val  in  1  result strobe.
REQ-012 o_wdt_err  out  1  one-cycle watchdog-abort pulse.

Function
REQ-013 Requesters SHALL hold val and opb stable until rdy; the arbiter SHALL never drop an offered request.
REQ-014 SHALL implement states IDLE, REQ (offer pending), and WAIT (accepted, awaiting result).
REQ-015 IDLE: grant = round-robin pick among valid requesters, starting at pointer ptr (0=al, 1=bj, 2=ag) and searching upward with wrap.
REQ-016 On any grant, hs_arb4cal_val=1 and o_cal_opb = opb of the granted requester, combinationally, in the same cycle.
REQ-017 Accept when hs_arb4cal_val & hs_cal4arb_rdy: the granted requester's rdy=1 that cycle; ptr <= granted+1 mod 3; state -> WAIT; owner register <= granted.
REQ-018 Grant without cal rdy: state -> REQ; owner register latches the grant.
REQ-019 REQ: grant locked to owner regardless of other requesters; accept per REQ-017.
REQ-020 WAIT: hs_arb4cal_val=0 and all rdy=0, except as in REQ-021.
REQ-021 WAIT & i_cal_res_val: o_<owner>_res = i_cal_res and o_<owner>_res_val = 1 in the same cycle; the arbiter SHALL re-arbitrate in that same cycle as if IDLE (back-to-back issue), otherwise -> IDLE.
REQ-022 i_cal_res_val outside WAIT SHALL be ignored; no res_val is asserted.
REQ-023 Non-owner res outputs SHALL be 0; o_cal_opb SHALL be 0 when hs_arb4cal_val=0.
REQ-024 The watchdog counter SHALL clear on entry to WAIT and increment each WAIT cycle without res_val; when it reaches WDT_MAX: o_wdt_err pulse, no res_val, state -> IDLE, and the owner request is considered consumed.
REQ-025 Latency: accept-to-result = cal latency + 0 cycles; minimum issue interval 1 cycle when cal returns in the cycle after accept.

Reset
REQ-026 rst (synchronous) SHALL force state=IDLE, ptr=0, owner=0, watchdog=0; all rdy, res_val, hs_arb4cal_val, and o_wdt_err = 0 in the cycle after rst is sampled high.
REQ-027 rst mid-REQ or mid-WAIT SHALL abandon the transaction without res_val; a late i_cal_res_val SHALL be ignored per REQ-022.

Structure
REQ-028 Requester-index encodings (AL=0, BJ=1, AG=2), the state encodings, and the WDT_MAX default SHALL live in the shared `cirno9_define` header; OPB_W reuses `CIRNO_CAL_OPB_SIZE`.
REQ-029 A single sub-module, cal_rr_pick (a 3-way round-robin priority picker: ptr, valid vector -> one-hot grant), is natural; everything else is flat.

Verification
REQ-030 Reset, then al val with cal rdy=1 and res_val one cycle later -> al rdy in cycle 0, o_al_res_val=1 with o_al_res=i_cal_res (e.g. 0x0000_00A5) in cycle 1, ptr=1.
REQ-031 All three valid continuously, cal rdy=1, 1-cycle result -> grant order al, bj, ag, al; one accept per cycle after the first.
REQ-032 bj valid, cal rdy=0 for 3 cycles, al raises val in cycle 1 -> grant stays bj (REQ) until rdy; al served next.
REQ-033 Accept then no res_val for 255 cycles -> o_wdt_err pulse on the 255th WAIT cycle, state IDLE, no res_val; a later stray i_cal_res_val is ignored.
REQ-034 rst asserted during WAIT, with res_val arriving the next cycle -> all outputs 0; no res_val; ptr=0.
